// File: rtl/csa_resolve_seq_if.sv
// csa_resolve_seq_if
// Bundles the operand-side and result-side handshakes of csa_resolve_seq.
//   in_valid/in_ready   : operand handshake (sum_vec, carry_vec)
//   out_valid/out_ready : result handshake (result)
//   busy                : resolver is in ADD or DONE
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A source holding valid keeps its
// data stable until that edge; ready may be high without valid.
// modport master: the producer/consumer side (drives operands, out_ready).
// modport slave : the resolver itself.
interface csa_resolve_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] result;
    logic             busy;

    modport master (
        output in_valid, sum_vec, carry_vec, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq
// Sequential carry-save resolver: turns a sum row and a carry row from a
// compressor tree into a plain binary value, result = sum_vec + 2*carry_vec,
// by rippling CHUNK bits per clock instead of one wide carry-propagate add.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   bus       : csa_resolve_seq_if.slave (operand/result handshakes, busy)
//   dbg_state : current FSM state (0 IDLE, 1 ADD, 2 DONE)
// Latency: result valid N edges after the accepting edge,
// N = ceil((WIDTH+2)/CHUNK).
module csa_resolve_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_resolve_seq_if.slave    bus,
    output logic [1:0]          dbg_state
);
    localparam int RW = WIDTH + 2;                   // exact result width
    localparam int N  = (RW + CHUNK - 1) / CHUNK;    // ADD cycles
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   a_q, a_d;
    logic [RW-1:0]   b_q, b_d;
    logic [RW-1:0]   res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            c_q, c_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [RW-1:0]    chunk_placed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;

        // Operands are stored only RW bits wide: the padding of the last
        // chunk reads as zeros shifted in, and any bits of the chunk sum that
        // land above RW fall off the placement shift.
        a_chunk      = CHUNK'(a_q >> (cnt_q * CHUNK));
        b_chunk      = CHUNK'(b_q >> (cnt_q * CHUNK));
        chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
        chunk_placed = RW'(chunk_sum[CHUNK-1:0]) << (cnt_q * CHUNK);

        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    a_d     = RW'(bus.sum_vec);
                    b_d     = RW'({bus.carry_vec, 1'b0});
                    res_d   = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // res starts at zero and chunks never overlap, so OR-ing the
                // freshly resolved chunk into place is an exact write.
                res_d = res_q | chunk_placed;
                c_d   = chunk_sum[CHUNK];
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = res_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_csa_resolve_seq.sv
module tb_csa_resolve_seq;
    localparam int WIDTH = 16;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csa_resolve_seq_if #(.WIDTH(WIDTH)) bus ();
    csa_resolve_seq_if #(.WIDTH(WIDTH)) bus1 ();
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;

    csa_resolve_seq #(.WIDTH(WIDTH), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Single-chunk configuration: CHUNK = WIDTH+2, one ADD cycle.
    csa_resolve_seq #(.WIDTH(WIDTH), .CHUNK(WIDTH + 2)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .dbg_state (dbg_state1)
    );

    int checks = 0;
    int errors = 0;
    logic [WIDTH+1:0] exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        int w;
        bus.sum_vec   = s;
        bus.carry_vec = c;
        bus.in_valid  = 1'b1;
        #1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid is seen; n = -1 if the bound expires.
    task automatic wait_out(input int limit, output int n);
        n = 0;
        while (!bus.out_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) n = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.sum_vec = '0; bus.carry_vec = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.sum_vec = '0; bus1.carry_vec = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.result !== 18'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, S_IDLE); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_max_value();
        logic exp_v;
        bus.out_ready = 1'b1;
        send(16'hFFFF, 16'hFFFF);
        for (int n = 0; n <= 5; n++) begin
            exp_v = (n == 5);
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL max_busy edge %0d got %b want 1", n, bus.busy); end
            checks++; if (bus.out_valid !== exp_v) begin errors++; $display("FAIL max_out_valid edge %0d got %b want %b", n, bus.out_valid, exp_v); end
            if (n < 5) @(negedge clk);
        end
        checks++; if (bus.result !== 18'h2FFFD) begin errors++; $display("FAIL max_result got %h want 2fffd", bus.result); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL max_out_valid_drop got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL max_busy_drop got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL max_in_ready_back got %b want 1", bus.in_ready); end
    endtask

    task automatic test_ripple();
        logic [WIDTH-1:0] sv [3];
        logic [WIDTH-1:0] cv [3];
        logic [WIDTH+1:0] ev [3];
        int n;
        sv = '{16'h7FFF, 16'h1234, 16'h0F0F};
        cv = '{16'h0001, 16'h0000, 16'hF0F0};
        ev = '{18'h08001, 18'h01234, 18'h1F0EF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(sv[i], cv[i]);
            wait_out(20, n);
            checks++; if (n != 5) begin errors++; $display("FAIL ripple_latency vec %0d got %0d want 5", i, n); end
            checks++; if (bus.result !== ev[i]) begin errors++; $display("FAIL ripple_result vec %0d got %h want %h", i, bus.result, ev[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h0001);
        wait_out(20, n);
        checks++; if (n != 5) begin errors++; $display("FAIL bp_latency got %0d want 5", n); end
        bus.in_valid  = 1'b1;
        bus.sum_vec   = 16'h0F0F;
        bus.carry_vec = 16'h00F0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", k, bus.out_valid); end
            checks++; if (bus.result !== 18'h01236) begin errors++; $display("FAIL bp_hold_result cycle %0d got %h want 01236", k, bus.result); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, bus.in_ready); end
            checks++; if (dbg_state !== S_DONE) begin errors++; $display("FAIL bp_state cycle %0d got %0d want %0d", k, dbg_state, S_DONE); end
            if (k < 3) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL bp_release_state got %0d want %0d", dbg_state, S_IDLE); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (dbg_state !== S_ADD) begin errors++; $display("FAIL bp_new_accept state got %0d want %0d", dbg_state, S_ADD); end
        wait_out(20, n);
        checks++; if (n != 5) begin errors++; $display("FAIL bp_new_latency got %0d want 5", n); end
        checks++; if (bus.result !== 18'h010EF) begin errors++; $display("FAIL bp_new_result got %h want 010ef", bus.result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bus.out_ready = 1'b1;
        send(16'hAAAA, 16'h5555);
        repeat (2) @(negedge clk);
        checks++; if (dbg_state !== S_ADD) begin errors++; $display("FAIL midrst_pre_state got %0d want %0d", dbg_state, S_ADD); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.result !== 18'h0) begin errors++; $display("FAIL midrst_result got %h want 0", bus.result); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL midrst_state got %0d want %0d", dbg_state, S_IDLE); end
        rst_n = 1'b1;
        send(16'h0003, 16'h0002);
        wait_out(20, n);
        checks++; if (n != 5) begin errors++; $display("FAIL midrst_next_latency got %0d want 5", n); end
        checks++; if (bus.result !== 18'h00007) begin errors++; $display("FAIL midrst_next_result got %h want 00007", bus.result); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, acc0, acc1, got;
        logic [WIDTH+1:0] e;
        exp_q = {};
        exp_q.push_back(18'h00001);
        exp_q.push_back(18'h18000);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.sum_vec   = 16'h0001;
        bus.carry_vec = 16'h0000;
        cyc = 0; acc0 = -1; acc1 = -1; got = 0;
        while (got < 2 && cyc < 40) begin
            if (bus.in_valid && bus.in_ready) begin
                if (acc0 < 0) acc0 = cyc; else acc1 = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                e = exp_q.pop_front();
                got++;
                checks++; if (bus.result !== e) begin errors++; $display("FAIL b2b_result %0d got %h want %h", got, bus.result, e); end
            end
            @(negedge clk);
            cyc++;
            if (acc1 >= 0) begin
                bus.in_valid = 1'b0;
            end else if (acc0 >= 0) begin
                bus.sum_vec   = 16'h8000;
                bus.carry_vec = 16'h8000;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (got != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got); end
        checks++; if (acc1 - acc0 != 7) begin errors++; $display("FAIL b2b_spacing got %0d want 7", acc1 - acc0); end
        @(negedge clk);
    endtask

    task automatic test_random();
        localparam int NUM = 300;
        int sent, recv, cyc;
        logic accepted;
        logic [WIDTH+1:0] e;
        exp_q = {};
        sent = 0; recv = 0; cyc = 0;
        bus.sum_vec   = WIDTH'($urandom_range(0, 65535));
        bus.carry_vec = WIDTH'($urandom_range(0, 65535));
        bus.in_valid  = 1'b1;
        while (recv < NUM && cyc < 20000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            accepted = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({2'b00, bus.sum_vec} + {1'b0, bus.carry_vec, 1'b0});
                sent++;
                accepted = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                recv++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra result %h with empty queue", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.result !== e) begin errors++; $display("FAIL rand_result %0d got %h want %h", recv, bus.result, e); end
                end
            end
            @(negedge clk);
            cyc++;
            if (accepted) begin
                if (sent < NUM) begin
                    bus.sum_vec   = WIDTH'($urandom_range(0, 65535));
                    bus.carry_vec = WIDTH'($urandom_range(0, 65535));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (recv != NUM) begin errors++; $display("FAIL rand_count got %0d want %0d", recv, NUM); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_single_chunk();
        bus1.out_ready = 1'b1;
        bus1.sum_vec   = 16'hFFFF;
        bus1.carry_vec = 16'hFFFF;
        bus1.in_valid  = 1'b1;
        #1;
        checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL one_in_ready got %b want 1", bus1.in_ready); end
        @(negedge clk);
        bus1.in_valid = 1'b0;
        checks++; if (dbg_state1 !== S_ADD) begin errors++; $display("FAIL one_state got %0d want %0d", dbg_state1, S_ADD); end
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL one_early_valid got %b want 0", bus1.out_valid); end
        @(negedge clk);
        checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL one_valid got %b want 1", bus1.out_valid); end
        checks++; if (bus1.result !== 18'h2FFFD) begin errors++; $display("FAIL one_result got %h want 2fffd", bus1.result); end
        @(negedge clk);
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL one_valid_drop got %b want 0", bus1.out_valid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_max_value();
        test_ripple();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_single_chunk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
